// File: rtl/apb_decode_wd.sv
`default_nettype none
// ============================================================================
// Module  : apb_decode_wd
// Purpose : APB 1:N address decoder with a per-transfer watchdog.
//           The port selected in the setup phase is held for the whole access
//           phase. A transfer that hangs for longer than TIMEOUT wait cycles
//           is aborted with PSLVERR, and that port is then marked dead.
//           Error completions are counted, and the address of the first
//           error is captured.
// Ports   : clk, reset                  - clock, async active-high reset
//           s_*                         - APB slave side (from the CPU bridge)
//           m_*                         - APB master side (to PORTS slaves);
//                                         paddr/pwrite/penable/pwdata pass
//                                         through, m_psel is one-hot
//           err_clr                     - pulse: clears port_dead/err_count/
//                                         err_valid
//           port_dead, err_count,
//           err_valid, err_addr         - error bookkeeping
// Revision: 1.0 - initial release
// ============================================================================
module apb_decode_wd #(
    parameter int          PORTS       = 4,
    parameter logic [31:0] BASE        = 32'd1024,
    parameter int          REGION_LOG2 = 12,
    parameter bit          TOP_DEFAULT = 1'b0,
    parameter int          TIMEOUT     = 255,
    parameter int          CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           s_paddr,
    input  logic                  s_pwrite,
    input  logic                  s_psel,
    input  logic                  s_penable,
    input  logic [31:0]           s_pwdata,
    output logic [31:0]           s_prdata,
    output logic                  s_pready,
    output logic                  s_pslverr,
    output logic [31:0]           m_paddr,
    output logic                  m_pwrite,
    output logic                  m_penable,
    output logic [31:0]           m_pwdata,
    output logic [PORTS-1:0]      m_psel,
    input  logic [PORTS*32-1:0]   m_prdata,
    input  logic [PORTS-1:0]      m_pready,
    input  logic [PORTS-1:0]      m_pslverr,
    input  logic                  err_clr,
    output logic [PORTS-1:0]      port_dead,
    output logic [CNT_W-1:0]      err_count,
    output logic                  err_valid,
    output logic [31:0]           err_addr
);

    localparam int               c_idx_w   = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int               c_wd_w    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [32:0]      c_base    = {1'b0, BASE};
    localparam logic [32:0]      c_limit   = c_base + (33'(PORTS) << REGION_LOG2);
    localparam logic [c_idx_w-1:0] c_top_idx = c_idx_w'(PORTS - 1);
    localparam logic [c_wd_w-1:0]  c_wd_max  = c_wd_w'(TIMEOUT);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_lerr;
    logic [31:0]          r_addr;
    logic [c_wd_w-1:0]    r_wait;
    logic [PORTS-1:0]     r_port_dead;
    logic [CNT_W-1:0]     r_err_count;
    logic                 r_err_valid;
    logic [31:0]          r_err_addr;

    function automatic logic [PORTS-1:0] f_onehot(input logic [c_idx_w-1:0] idx);
        f_onehot = '0;
        for (int i = 0; i < PORTS; i++) begin
            f_onehot[i] = (i == int'(idx));
        end
    endfunction

    // Pass-through of the shared APB signals.
    assign m_paddr   = s_paddr;
    assign m_pwrite  = s_pwrite;
    assign m_penable = s_penable;
    assign m_pwdata  = s_pwdata;

    // ------------------------------------------------------------------
    // Setup-phase address decode
    // ------------------------------------------------------------------
    logic                 w_hit;
    logic [31:0]          w_offset;
    logic [31:0]          w_off_idx;
    logic [c_idx_w-1:0]   w_dec_idx;
    logic                 w_dec_lerr;
    logic                 w_unused;

    assign w_hit     = ({1'b0, s_paddr} >= c_base) && ({1'b0, s_paddr} < c_limit);
    assign w_offset  = s_paddr - BASE;
    assign w_off_idx = w_offset >> REGION_LOG2;
    assign w_dec_idx = w_hit ? w_off_idx[c_idx_w-1:0] : c_top_idx;
    assign w_unused  = ^w_off_idx[31:c_idx_w];

    // A miss is local unless it defaults to the top port. A dead target is
    // also local, so the hung slave is not selected again.
    assign w_dec_lerr = (!w_hit && !TOP_DEFAULT) || |(r_port_dead & f_onehot(w_dec_idx));

    // ------------------------------------------------------------------
    // Latched-port response mux
    // ------------------------------------------------------------------
    logic                 w_sel_ready;
    logic                 w_sel_err;
    logic [31:0]          w_sel_rdata;

    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (i == int'(r_idx)) begin
                w_sel_ready = m_pready[i];
                w_sel_err   = m_pslverr[i];
                w_sel_rdata = m_prdata[i*32 +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and APB outputs
    // ------------------------------------------------------------------
    logic                 w_setup;
    logic                 w_wait_inc;
    logic                 w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        m_psel      = '0;
        s_pready    = 1'b0;
        s_pslverr   = 1'b0;
        s_prdata    = '0;
        w_setup     = 1'b0;
        w_wait_inc  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A lone PENABLE in IDLE is a protocol violation and is ignored.
                if (s_psel && !s_penable) begin
                    w_setup     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                    if (!w_dec_lerr) m_psel = f_onehot(w_dec_idx);
                end
            end
            ST_ACCESS: begin
                if (!s_psel) begin
                    // Master abandoned the transfer; nothing completes or logs.
                    w_state_nxt = ST_IDLE;
                end else begin
                    if (!r_lerr) m_psel = f_onehot(r_idx);
                    if (r_lerr) begin
                        s_pready    = 1'b1;
                        s_pslverr   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_sel_ready) begin
                        // A ready slave wins over a coincident timeout.
                        s_pready    = 1'b1;
                        s_pslverr   = w_sel_err;
                        s_prdata    = w_sel_rdata;
                        w_state_nxt = ST_IDLE;
                    end else if ((TIMEOUT != 0) && (r_wait == c_wd_max)) begin
                        s_pready    = 1'b1;
                        s_pslverr   = 1'b1;
                        w_timeout   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        s_prdata    = w_sel_rdata;
                        w_wait_inc  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Error bookkeeping. A clear is applied first, so an error in the same
    // cycle is recorded into the freshly cleared state.
    // ------------------------------------------------------------------
    logic                 w_err_done;
    logic [PORTS-1:0]     w_dead_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_valid_nxt;
    logic [31:0]          w_addr_nxt;

    assign w_err_done = s_pready & s_pslverr;

    always_comb begin
        w_dead_nxt  = err_clr ? '0   : r_port_dead;
        w_cnt_nxt   = err_clr ? '0   : r_err_count;
        w_valid_nxt = err_clr ? 1'b0 : r_err_valid;
        w_addr_nxt  = r_err_addr;
        if (w_timeout) w_dead_nxt = w_dead_nxt | f_onehot(r_idx);
        if (w_err_done) begin
            if (w_cnt_nxt != '1) w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
            if (!w_valid_nxt) begin
                w_addr_nxt  = r_addr;
                w_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_lerr      <= 1'b0;
            r_addr      <= '0;
            r_wait      <= '0;
            r_port_dead <= '0;
            r_err_count <= '0;
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_setup) begin
                r_idx  <= w_dec_idx;
                r_lerr <= w_dec_lerr;
                r_addr <= s_paddr;
                r_wait <= '0;
            end else if (w_wait_inc) begin
                r_wait <= r_wait + c_wd_w'(1);
            end
            r_port_dead <= w_dead_nxt;
            r_err_count <= w_cnt_nxt;
            r_err_valid <= w_valid_nxt;
            r_err_addr  <= w_addr_nxt;
        end
    end

    assign port_dead = r_port_dead;
    assign err_count = r_err_count;
    assign err_valid = r_err_valid;
    assign err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_apb_decode_wd.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_decode_wd
// Purpose : Scoreboard bench for apb_decode_wd (4 ports, BASE 0x400, 4 KiB
//           regions, local miss errors, TIMEOUT 3, 2-bit error counter).
// Revision: 1.0 - initial release
// ============================================================================
module tb_apb_decode_wd;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   s_paddr = '0;
    logic          s_pwrite = 1'b0;
    logic          s_psel = 1'b0;
    logic          s_penable = 1'b0;
    logic [31:0]   s_pwdata = '0;
    logic [31:0]   s_prdata;
    logic          s_pready;
    logic          s_pslverr;
    logic [31:0]   m_paddr;
    logic          m_pwrite;
    logic          m_penable;
    logic [31:0]   m_pwdata;
    logic [3:0]    m_psel;
    logic [127:0]  m_prdata;
    logic [3:0]    m_pready = '0;
    logic [3:0]    m_pslverr = '0;
    logic          err_clr = 1'b0;
    logic [3:0]    port_dead;
    logic [1:0]    err_count;
    logic          err_valid;
    logic [31:0]   err_addr;

    // Port i returns 0xD000_0000 | i*0x1111.
    assign m_prdata = {32'hD000_3333, 32'hD000_2222, 32'hD000_1111, 32'hD000_0000};

    apb_decode_wd #(
        .PORTS(4), .BASE(32'd1024), .REGION_LOG2(12),
        .TOP_DEFAULT(1'b0), .TIMEOUT(3), .CNT_W(2)
    ) dut (
        .clk(clk), .reset(reset),
        .s_paddr(s_paddr), .s_pwrite(s_pwrite), .s_psel(s_psel),
        .s_penable(s_penable), .s_pwdata(s_pwdata),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .m_paddr(m_paddr), .m_pwrite(m_pwrite), .m_penable(m_penable),
        .m_pwdata(m_pwdata), .m_psel(m_psel),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .err_clr(err_clr), .port_dead(port_dead), .err_count(err_count),
        .err_valid(err_valid), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  psel;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   acc_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts access-phase cycles and checks every completion
    // against the oldest queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            acc_cyc = 0;
        end else if (s_psel && !s_penable) begin
            acc_cyc = 0;
        end else if (s_psel && s_penable) begin
            acc_cyc++;
            if (s_pready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 64'(s_paddr), 64'hFFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("prdata", 64'(s_prdata), 64'(e.rdata));
                    chk("pslverr", 64'(s_pslverr), 64'(e.err));
                    chk("psel_access", 64'(m_psel), 64'(e.psel));
                    chk("access_cycles", 64'(acc_cyc), 64'(e.cyc));
                end
            end
        end
    end

    // One APB transfer. The addressed slaves assert ready from access cycle
    // rdy_cyc onward; err_clr is pulsed in access cycle clr_cyc (0 = never).
    task automatic xfer(input logic [31:0] addr, input logic wr,
                        input logic [3:0] rdy_mask, input int rdy_cyc,
                        input logic [3:0] err_mask, input int clr_cyc,
                        input logic [3:0] exp_psel, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_cyc);
        exp_t e;
        bit   done;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.psel  = exp_psel;
        e.cyc   = exp_cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        s_psel = 1'b1; s_penable = 1'b0; s_paddr = addr; s_pwrite = wr;
        s_pwdata = ~addr; m_pslverr = err_mask;
        @(negedge clk);
        chk("psel_setup", 64'(m_psel), 64'(exp_psel));
        @(posedge clk); #1;
        s_penable = 1'b1;
        done = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            m_pready = (c >= rdy_cyc) ? rdy_mask : 4'b0000;
            err_clr  = (c == clr_cyc);
            @(negedge clk);
            if (s_pready) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) begin
            chk("transfer_bound", 64'(0), 64'(1));
            void'(sb.pop_front());
        end
        err_clr = 1'b0; m_pready = '0; m_pslverr = '0;
        s_psel = 1'b0; s_penable = 1'b0;
    endtask

    task automatic chk_err(input logic [1:0] cnt, input logic vld,
                           input logic [31:0] addr, input logic [3:0] dead);
        chk("err_count", 64'(err_count), 64'(cnt));
        chk("err_valid", 64'(err_valid), 64'(vld));
        chk("err_addr", 64'(err_addr), 64'(addr));
        chk("port_dead", 64'(port_dead), 64'(dead));
    endtask

    initial begin
        #12;
        chk("reset_psel", 64'(m_psel), 64'(0));
        chk("reset_pready", 64'(s_pready), 64'(0));
        chk_err(2'd0, 1'b0, 32'h0, 4'b0000);
        @(negedge clk); reset = 1'b0;

        //    addr          wr    rdy      cyc err     clr psel     rdata           err cyc
        xfer(32'h0000_1400, 1'b0, 4'b0010, 1, 4'b0000, 0, 4'b0010, 32'hD000_1111, 1'b0, 1);
        chk_err(2'd0, 1'b0, 32'h0, 4'b0000);
        xfer(32'h0000_4400, 1'b0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 32'h0,         1'b1, 1);
        chk_err(2'd1, 1'b1, 32'h4400, 4'b0000);
        xfer(32'h0000_2500, 1'b0, 4'b0100, 2, 4'b0100, 0, 4'b0100, 32'hD000_2222, 1'b1, 2);
        chk_err(2'd2, 1'b1, 32'h4400, 4'b0000);
        xfer(32'h0000_43FC, 1'b0, 4'b1000, 1, 4'b0000, 0, 4'b1000, 32'hD000_3333, 1'b0, 1);
        xfer(32'h0000_0400, 1'b1, 4'b0000, 99, 4'b0000, 0, 4'b0001, 32'h0,        1'b1, 4);
        chk_err(2'd3, 1'b1, 32'h4400, 4'b0001);
        xfer(32'h0000_0400, 1'b0, 4'b0001, 1, 4'b0000, 0, 4'b0000, 32'h0,         1'b1, 1);
        xfer(32'h0000_03FC, 1'b0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 32'h0,         1'b1, 1);
        chk_err(2'd3, 1'b1, 32'h4400, 4'b0001);
        xfer(32'h0000_5000, 1'b0, 4'b0000, 1, 4'b0000, 1, 4'b0000, 32'h0,         1'b1, 1);
        chk_err(2'd1, 1'b1, 32'h5000, 4'b0000);
        xfer(32'h0000_0800, 1'b0, 4'b0001, 4, 4'b0000, 0, 4'b0001, 32'hD000_0000, 1'b0, 4);
        chk_err(2'd1, 1'b1, 32'h5000, 4'b0000);
        xfer(32'h0000_3000, 1'b1, 4'b0000, 99, 4'b0000, 4, 4'b0100, 32'h0,        1'b1, 4);
        chk_err(2'd1, 1'b1, 32'h3000, 4'b0100);

        // PENABLE without a setup phase must be ignored for both cycles.
        @(posedge clk); #1;
        s_psel = 1'b1; s_penable = 1'b1; s_paddr = 32'h0000_1400; m_pready = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stray_penable_psel", 64'(m_psel), 64'(0));
            chk("stray_penable_pready", 64'(s_pready), 64'(0));
        end
        @(posedge clk); #1;
        s_psel = 1'b0; s_penable = 1'b0; m_pready = '0;

        xfer(32'h0000_2400, 1'b0, 4'b0100, 1, 4'b0000, 0, 4'b0000, 32'h0,         1'b1, 1);
        chk_err(2'd2, 1'b1, 32'h3000, 4'b0100);

        // Reset asserted in access cycle 2 of a hung transfer.
        @(posedge clk); #1;
        s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h0000_1800; s_pwrite = 1'b1;
        @(negedge clk);
        chk("psel_setup_rst", 64'(m_psel), 64'(4'b0010));
        @(posedge clk); #1;
        s_penable = 1'b1;
        @(posedge clk); #1;
        chk("psel_before_rst", 64'(m_psel), 64'(4'b0010));
        reset = 1'b1;
        #1;
        chk("psel_in_rst", 64'(m_psel), 64'(0));
        chk("pready_in_rst", 64'(s_pready), 64'(0));
        chk_err(2'd0, 1'b0, 32'h0, 4'b0000);
        s_psel = 1'b0; s_penable = 1'b0;
        @(negedge clk); reset = 1'b0;

        xfer(32'h0000_1400, 1'b0, 4'b0010, 1, 4'b0000, 0, 4'b0010, 32'hD000_1111, 1'b0, 1);
        xfer(32'h0000_2400, 1'b0, 4'b0100, 1, 4'b0000, 0, 4'b0100, 32'hD000_2222, 1'b0, 1);
        chk_err(2'd0, 1'b0, 32'h0, 4'b0000);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #20000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/apb_decode_wd.md
Name: apb_decode_wd

Overview:
Parametrised APB 1:N address decoder with a per-transfer watchdog and error bookkeeping. It sits between one APB master (the CPU bridge) and PORTS peripheral slaves, each occupying a power-of-two region. Unlike a purely combinational decoder, it latches the selected port for the access phase and aborts hung transfers with PSLVERR. Timed-out ports are marked dead until software clears them, and the block counts errors and captures the first failing address.

Parameters:
PORTS, 4, number of master-side ports (1..64)
BASE, 1024, byte address of port 0 region (inclusive)
REGION_LOG2, 12, log2 of region size in bytes; port i spans BASE+i*2^REGION_LOG2 .. +2^REGION_LOG2-1
TOP_DEFAULT, 0, 1: unmapped accesses are routed to port PORTS-1; 0: unmapped accesses complete locally with error
TIMEOUT, 255, maximum access-phase wait cycles before abort; 0 disables the watchdog
CNT_W, 8, error counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
s_paddr  in  32  slave APB address
s_pwrite  in  1  slave write strobe
s_psel  in  1  slave select
s_penable  in  1  slave enable
s_pwdata  in  32  slave write data
s_prdata  out  32  read data returned to master
s_pready  out  1  ready returned to master
s_pslverr  out  1  error returned to master
m_paddr  out  32  pass-through of s_paddr
m_pwrite  out  1  pass-through
m_penable  out  1  pass-through
m_pwdata  out  32  pass-through
m_psel  out  PORTS  one-hot port select
m_prdata  in  PORTS*32  per-port read data, port i at [i*32+:32]
m_pready  in  PORTS  per-port ready
m_pslverr  in  PORTS  per-port error
err_clr  in  1  single-cycle pulse: clears port_dead, err_count, err_valid
port_dead  out  PORTS  sticky: port timed out
err_count  out  CNT_W  saturating count of error completions
err_valid  out  1  err_addr holds a captured address
err_addr  out  32  s_paddr of the first error since reset or clear

Behaviour:
- Decode: hit when BASE <= s_paddr < BASE+(PORTS<<REGION_LOG2). Index = (s_paddr-BASE)>>REGION_LOG2. Miss with TOP_DEFAULT=1 maps to index PORTS-1.
- A transfer is local-error when it is a miss with TOP_DEFAULT=0, or when it targets a port whose port_dead bit is set.
- FSM has two states, IDLE and ACCESS. Reset state is IDLE. Reset values: m_psel=0, port_dead=0, err_count=0, err_valid=0, err_addr=0, watchdog count=0.
- IDLE, s_psel=1 and s_penable=0 (setup phase):
  - m_psel is driven combinationally to the one-hot decoded index, or all-zero if local-error.
  - Index, local-error flag and s_paddr are latched.
  - Next state is ACCESS.
- IDLE, any other input: m_psel=0, s_pready=0, s_pslverr=0, s_prdata=0.
- ACCESS: m_psel is driven from the latched index (0 if local-error). s_prdata and s_pready come from the latched port, so good transfers add zero wait states.
- ACCESS completion is the first matching case below, in priority order:
  1. local-error: s_pready=1 and s_pslverr=1 in the first ACCESS cycle.
  2. m_pready[idx]=1: s_pready=1 and s_pslverr=m_pslverr[idx]. A normal completion wins over a simultaneous timeout.
  3. TIMEOUT!=0 and wait count==TIMEOUT: s_pready=1, s_pslverr=1, s_prdata=0, and port_dead[idx] is set.
  4. Otherwise the wait count increments and the FSM stays in ACCESS.
- The wait count clears on entry to ACCESS, so an access phase lasts at most TIMEOUT+1 cycles.
- On completion: state returns to IDLE and m_psel drops next cycle. A back-to-back setup in the following cycle is accepted.
- An abandoned slave sees psel fall without receiving pready. This is intended.
- Error completion means s_pready=1 and s_pslverr=1 from any source.
  - err_count increments on each error completion and saturates at all-ones.
  - If err_valid=0, err_addr takes the latched address and err_valid is set.
- err_clr applies before any same-cycle error. That error is therefore recorded: count=1, address captured, and a timed-out port stays dead.
- s_penable=1 while in IDLE (protocol violation) is ignored. There is no state change and no select.
- s_psel dropping mid-ACCESS returns the FSM to IDLE with no completion and no error logged.
- Asynchronous reset at any time forces IDLE and all reset values immediately.

Test Plan:
- Read 0x1400 (port 1), m_pready[1] high in the first ACCESS cycle -> m_psel=4'b0010 in both phases; s_prdata=m_prdata[63:32]; s_pready in ACCESS cycle 1; err_count=0.
- Read 0x4400 with TOP_DEFAULT=0 -> m_psel=0; s_pready=1 and s_pslverr=1 in ACCESS cycle 1; err_count=1; err_addr=0x4400; err_valid=1.
- TIMEOUT=3, write to 0x0400 with m_pready[0] held low -> abort in ACCESS cycle 4 with s_pslverr=1; port_dead=4'b0001; a following access to 0x0400 errors immediately with m_psel=0.
- TIMEOUT=3, m_pready[0] rises in ACCESS cycle 4 -> normal completion with s_pslverr=m_pslverr[0]; port_dead stays 0.
- err_clr pulsed in the same cycle as a decode error -> err_count=1, err_valid=1, err_addr=new address; CNT_W=2 with 5 errors -> err_count=3.
- Assert reset in ACCESS cycle 2 of a waiting transfer -> m_psel=0 immediately; s_pready=0; counters=0; a new setup after reset decodes normally.
